pll_lock_seq: RTL and testbench
===============================

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 Parameter PWD_CYCLES, 10, number of clk cycles pll_pwd is held high at power-up.
REQ-002 Parameter RST_CYCLES, 10, number of clk cycles pll_rst is held high per reset attempt.
REQ-003 Parameter LOCK_TIMEOUT, 100000, number of clk cycles allowed for lock per attempt.
REQ-004 Parameter LOCK_STABLE, 64, number of consecutive synced-lock cycles required before ready.
REQ-005 Parameter MAX_RETRY, 3, number of timed-out attempts allowed before FAIL.
REQ-006 Parameter ODIV_INIT, 100, reset value of dyn_odiv0.
REQ-007 Parameter DUTY_INIT, 100, reset value of dyn_duty0.
REQ-008 Ports SHALL be exactly as listed below; there is one clock; reset is asynchronous and active-low.
REQ-009 clk  in  1  system clock.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 pll_lock  in  1  PLL lock; asynchronous to clk.
REQ-012 cfg_req  in  1  level request for new divider settings; held until acknowledged.
REQ-013 cfg_odiv / cfg_duty  in  10 each  requested output divider and duty.
REQ-014 cfg_ack  out  1  one-cycle acknowledge of cfg_req.
REQ-015 pll_pwd / pll_rst  out  1 each  PLL power-down and reset.
REQ-016 dyn_odiv0 / dyn_duty0  out  10 each  dynamic divider and duty to the PLL.
REQ-017 clk_ready  out  1  PLL output is locked and stable.
REQ-018 busy  out  1  high in every state except READY and FAIL.
REQ-019 err  out  1  sticky failure flag.
REQ-020 retry_cnt  out  2  number of timed-out attempts in the current sequence.

Function
REQ-021 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before use; this adds 2 cycles of latency.
REQ-022 States SHALL be PWD, RST, WAIT_LOCK, STABLE, READY and FAIL.
REQ-023 PWD state: pll_pwd=1 and pll_rst=1 for PWD_CYCLES cycles, then the block SHALL move to RST.
REQ-024 RST state: pll_pwd=0 and pll_rst=1 for RST_CYCLES cycles, then the block SHALL move to WAIT_LOCK with the timer cleared.
REQ-025 WAIT_LOCK state: pll_rst=0 and the timer increments; lock_s=1 SHALL move to STABLE.
REQ-026 WAIT_LOCK timeout (timer reaches LOCK_TIMEOUT-1): retry_cnt increments; if the new value equals MAX_RETRY, go to FAIL, otherwise go to RST.
REQ-027 STABLE state: count consecutive lock_s=1 cycles; on reaching LOCK_STABLE, go to READY; lock_s=0 SHALL clear the count and return to WAIT_LOCK with the timer cleared.
REQ-028 READY state: clk_ready=1, busy=0, retry_cnt cleared to 0.
REQ-029 READY with cfg_req=1 and lock_s=1: latch cfg_odiv/cfg_duty into dyn_odiv0/dyn_duty0, pulse cfg_ack for 1 cycle, drop clk_ready, and go to RST in the same edge.
REQ-030 A latched value of 0 SHALL be replaced by 1 (applies to both odiv and duty).
REQ-031 cfg_req outside READY SHALL NOT be acknowledged; it stays pending until READY.
REQ-032 In READY, lock loss SHALL take priority over a simultaneous cfg_req; the request stays pending.
REQ-033 FAIL state: pll_rst=1, pll_pwd=0, err=1, clk_ready=0; cfg_req ignored; the only exit is rst_n.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 While rst_n=0: state=PWD, pll_pwd=1, pll_rst=1, dyn_odiv0=ODIV_INIT, dyn_duty0=DUTY_INIT, cfg_ack=0, clk_ready=0, busy=1, err=0, retry_cnt=0, all counters 0, synchronizer 0.
REQ-036 Reset asserted mid-sequence, including in READY or FAIL, SHALL abort immediately and restart from PWD after release.

Configuration
REQ-037 Macro PLL_AUTO_RELOCK_EN defined: lock_s=0 in READY drops clk_ready and goes to RST with retry_cnt=0.
REQ-038 Macro PLL_AUTO_RELOCK_EN undefined: lock_s=0 in READY drops clk_ready, sets err, and goes to FAIL.

Verification (PWD_CYCLES=4, RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, MAX_RETRY=3)
REQ-039 Power-up: release rst_n, pll_lock rises 10 cycles after pll_rst falls -> pwd 4 cycles, rst 4 cycles, clk_ready rises 2+8 cycles after the lock rise; busy=0.
REQ-040 Glitch: pll_lock high 5 cycles, low 1, then high -> no clk_ready until 8 unbroken synced-high cycles.
REQ-041 Timeout: pll_lock stuck low -> 3 attempts of (4 rst + 50 wait) cycles, retry_cnt 1,2,3, then FAIL with err=1 and pll_rst=1.
REQ-042 Reconfig: in READY apply cfg_req with odiv=200, duty=200 -> 1-cycle cfg_ack, dyn_odiv0=200, dyn_duty0=200, pll_rst high 4 cycles, clk_ready returns after relock; cfg_odiv=0 -> dyn_odiv0=1.
REQ-043 Lock loss in READY together with cfg_req -> no ack; with macro, relock then ack in READY; without macro, FAIL with err=1.
REQ-044 rst_n pulsed low during WAIT_LOCK -> all outputs at reset values, then the sequence restarts from PWD.

Source files
------------

// File: rtl/pll_lock_seq.sv
// PLL power-up / lock sequencer with retry, lock-stability qualification and dynamic divider reconfiguration.
// Optional macro PLL_AUTO_RELOCK_EN: lock loss in READY relocks instead of latching FAIL.
module pll_lock_seq #(
  parameter int          PWD_CYCLES   = 10,
  parameter int          RST_CYCLES   = 10,
  parameter int          LOCK_TIMEOUT = 100000,
  parameter int          LOCK_STABLE  = 64,
  parameter int          MAX_RETRY    = 3,
  parameter logic [9:0]  ODIV_INIT    = 10'd100,
  parameter logic [9:0]  DUTY_INIT    = 10'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       cfg_req,
  input  logic [9:0] cfg_odiv,
  input  logic [9:0] cfg_duty,
  output logic       cfg_ack,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic [9:0] dyn_odiv0,
  output logic [9:0] dyn_duty0,
  output logic       clk_ready,
  output logic       busy,
  output logic       err,
  output logic [1:0] retry_cnt
);

  localparam logic [2:0] S_PWD       = 3'd0;
  localparam logic [2:0] S_RST       = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_STABLE    = 3'd3;
  localparam logic [2:0] S_READY     = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  // One shared counter serves every timed state, so it is sized for the longest interval.
  localparam int MAX_A   = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int MAX_B   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          lock_meta;
  logic          lock_s;
  logic [2:0]    retry_inc;

  assign retry_inc = {1'b0, retry_cnt} + 3'd1;

  function automatic logic [9:0] nz(input logic [9:0] v);
    return (v == 10'd0) ? 10'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // NOTE: every register here is sequential state, so only non-blocking assignments are used;
  // blocking ones would let later statements see same-edge values and break the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWD;
      cnt       <= '0;
      pll_pwd   <= 1'b1;
      pll_rst   <= 1'b1;
      dyn_odiv0 <= ODIV_INIT;
      dyn_duty0 <= DUTY_INIT;
      cfg_ack   <= 1'b0;
      clk_ready <= 1'b0;
      busy      <= 1'b1;
      err       <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        S_PWD: begin
          if (cnt == CW'(PWD_CYCLES - 1)) begin
            state   <= S_RST;
            cnt     <= '0;
            pll_pwd <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // The cycle that detects lock already counts as the first stable cycle.
          if (lock_s) begin
            if (LOCK_STABLE <= 1) begin
              state     <= S_READY;
              clk_ready <= 1'b1;
              busy      <= 1'b0;
              retry_cnt <= 2'd0;
            end else begin
              state <= S_STABLE;
              cnt   <= CW'(1);
            end
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_cnt <= retry_inc[1:0];
            pll_rst   <= 1'b1;
            cnt       <= '0;
            if (retry_inc == 3'(MAX_RETRY)) begin
              state <= S_FAIL;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_RST;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(LOCK_STABLE - 1)) begin
            state     <= S_READY;
            cnt       <= '0;
            clk_ready <= 1'b1;
            busy      <= 1'b0;
            retry_cnt <= 2'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READY: begin
          // Lock loss wins over a simultaneous request; the request simply stays pending.
          if (!lock_s) begin
            clk_ready <= 1'b0;
            pll_rst   <= 1'b1;
            cnt       <= '0;
`ifdef PLL_AUTO_RELOCK_EN
            state     <= S_RST;
            busy      <= 1'b1;
            retry_cnt <= 2'd0;
`else
            state     <= S_FAIL;
            err       <= 1'b1;
`endif
          end else if (cfg_req) begin
            state     <= S_RST;
            cnt       <= '0;
            dyn_odiv0 <= nz(cfg_odiv);
            dyn_duty0 <= nz(cfg_duty);
            cfg_ack   <= 1'b1;
            clk_ready <= 1'b0;
            busy      <= 1'b1;
            pll_rst   <= 1'b1;
          end
        end
        S_FAIL: begin
          pll_rst   <= 1'b1;
          pll_pwd   <= 1'b0;
          clk_ready <= 1'b0;
          busy      <= 1'b0;
          err       <= 1'b1;
        end
        default: begin
          state <= S_FAIL;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: stimulus queues timed output events, a monitor matches every output change.
// Expectations follow PLL_AUTO_RELOCK_EN when it is defined for the bench build.
module tb_pll_lock_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       cfg_req;
  logic [9:0] cfg_odiv;
  logic [9:0] cfg_duty;
  logic       cfg_ack;
  logic       pll_pwd;
  logic       pll_rst;
  logic [9:0] dyn_odiv0;
  logic [9:0] dyn_duty0;
  logic       clk_ready;
  logic       busy;
  logic       err;
  logic [1:0] retry_cnt;

  pll_lock_seq #(
    .PWD_CYCLES(4), .RST_CYCLES(4), .LOCK_TIMEOUT(50), .LOCK_STABLE(8), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_req(cfg_req),
    .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty), .cfg_ack(cfg_ack),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .dyn_odiv0(dyn_odiv0), .dyn_duty0(dyn_duty0),
    .clk_ready(clk_ready), .busy(busy), .err(err), .retry_cnt(retry_cnt)
  );

  typedef struct {
    int          cyc;
    logic [27:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   evt      = 0;
  bit   done     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since the last reset release; an output change at edge k is seen with cyc == k.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [27:0] tup(input logic pwd, rst, rdy, ack, bsy, er,
                                      input logic [1:0] rc, input logic [9:0] od, du);
    return {pwd, rst, rdy, ack, bsy, er, rc, od, du};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  task automatic expect_at(input int c, input logic [27:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_at(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != n && guard < 2000);
    if (cyc != n) check($sformatf("wait_cycle_%0d", n), 32'(cyc), 32'(n));
    #1;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #1;
    expect_at(0, tup(1, 1, 0, 0, 1, 0, 2'd0, 10'd100, 10'd100));
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    cfg_req  = 1'b0;
  endtask

  // Release reset and queue the power-down / reset phases that always follow it.
  task automatic release_reset();
    repeat (3) @(negedge clk);
    #1;
    expect_at(4, tup(0, 1, 0, 0, 1, 0, 2'd0, 10'd100, 10'd100));
    expect_at(8, tup(0, 0, 0, 0, 1, 0, 2'd0, 10'd100, 10'd100));
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [27:0] cur;
    logic [27:0] prev;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {pll_pwd, pll_rst, clk_ready, cfg_ack, busy, err, retry_cnt, dyn_odiv0, dyn_duty0};
      if (!done && cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change cycle=%0d actual=0x%h required=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("evt%0d_cycle", evt), 32'(cyc), 32'(e.cyc));
          check($sformatf("evt%0d_outputs", evt), {4'h0, cur}, {4'h0, e.val});
          evt++;
        end
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    cfg_req  = 1'b0;
    cfg_odiv = 10'd0;
    cfg_duty = 10'd0;
    expect_at(0, tup(1, 1, 0, 0, 1, 0, 2'd0, 10'd100, 10'd100));

    // Power-up: lock rises 10 cycles after pll_rst falls; ready 2+8 cycles later.
    release_reset();
    expect_at(28, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd100, 10'd100));
    wait_at(18);
    pll_lock = 1'b1;
    wait_at(32);

    // Glitch: 5 high, 1 low, then high; the stable count restarts after the dip.
    assert_reset();
    release_reset();
    expect_at(26, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd100, 10'd100));
    wait_at(10);
    pll_lock = 1'b1;
    wait_at(15);
    pll_lock = 1'b0;
    wait_at(16);
    pll_lock = 1'b1;

    // Reconfiguration, including zero replacement of odiv and of duty.
    expect_at(31, tup(0, 1, 0, 1, 1, 0, 2'd0, 10'd200, 10'd200));
    expect_at(32, tup(0, 1, 0, 0, 1, 0, 2'd0, 10'd200, 10'd200));
    expect_at(35, tup(0, 0, 0, 0, 1, 0, 2'd0, 10'd200, 10'd200));
    expect_at(43, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd200, 10'd200));
    expect_at(46, tup(0, 1, 0, 1, 1, 0, 2'd0, 10'd1,   10'd333));
    expect_at(47, tup(0, 1, 0, 0, 1, 0, 2'd0, 10'd1,   10'd333));
    expect_at(50, tup(0, 0, 0, 0, 1, 0, 2'd0, 10'd1,   10'd333));
    expect_at(58, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd1,   10'd333));
    expect_at(61, tup(0, 1, 0, 1, 1, 0, 2'd0, 10'd517, 10'd1));
    expect_at(62, tup(0, 1, 0, 0, 1, 0, 2'd0, 10'd517, 10'd1));
    expect_at(65, tup(0, 0, 0, 0, 1, 0, 2'd0, 10'd517, 10'd1));
    expect_at(73, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd517, 10'd1));
    wait_at(30);
    cfg_req = 1'b1; cfg_odiv = 10'd200; cfg_duty = 10'd200;
    wait_at(31);
    cfg_req = 1'b0;
    wait_at(45);
    cfg_req = 1'b1; cfg_odiv = 10'd0; cfg_duty = 10'd333;
    wait_at(46);
    cfg_req = 1'b0;
    wait_at(60);
    cfg_req = 1'b1; cfg_odiv = 10'd517; cfg_duty = 10'd0;
    wait_at(61);
    cfg_req = 1'b0;

    // Lock loss in READY on the same edge as a request: the request must not be acked then.
`ifdef PLL_AUTO_RELOCK_EN
    expect_at(78,  tup(0, 1, 0, 0, 1, 0, 2'd0, 10'd517, 10'd1));
    expect_at(82,  tup(0, 0, 0, 0, 1, 0, 2'd0, 10'd517, 10'd1));
    expect_at(95,  tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd517, 10'd1));
    expect_at(96,  tup(0, 1, 0, 1, 1, 0, 2'd0, 10'd300, 10'd400));
    expect_at(97,  tup(0, 1, 0, 0, 1, 0, 2'd0, 10'd300, 10'd400));
    expect_at(100, tup(0, 0, 0, 0, 1, 0, 2'd0, 10'd300, 10'd400));
    expect_at(108, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd300, 10'd400));
`else
    expect_at(78,  tup(0, 1, 0, 0, 0, 1, 2'd0, 10'd517, 10'd1));
`endif
    wait_at(75);
    pll_lock = 1'b0;
    wait_at(77);
    cfg_req = 1'b1; cfg_odiv = 10'd300; cfg_duty = 10'd400;
    wait_at(85);
    pll_lock = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
    wait_at(96);
    cfg_req = 1'b0;
`else
    wait_at(100);
    cfg_req = 1'b0;
`endif
    wait_at(110);

    // Lock timeout: three attempts then FAIL; requests outside READY are ignored.
    assert_reset();
    release_reset();
    expect_at(58,  tup(0, 1, 0, 0, 1, 0, 2'd1, 10'd100, 10'd100));
    expect_at(62,  tup(0, 0, 0, 0, 1, 0, 2'd1, 10'd100, 10'd100));
    expect_at(112, tup(0, 1, 0, 0, 1, 0, 2'd2, 10'd100, 10'd100));
    expect_at(116, tup(0, 0, 0, 0, 1, 0, 2'd2, 10'd100, 10'd100));
    expect_at(166, tup(0, 1, 0, 0, 0, 1, 2'd3, 10'd100, 10'd100));
    wait_at(20);
    cfg_req = 1'b1; cfg_odiv = 10'd11; cfg_duty = 10'd22;
    wait_at(180);
    cfg_req = 1'b0;

    // Reset pulsed during WAIT_LOCK aborts and restarts from PWD.
    assert_reset();
    release_reset();
    wait_at(20);
    assert_reset();
    release_reset();
    expect_at(20, tup(0, 0, 1, 0, 0, 0, 2'd0, 10'd100, 10'd100));
    wait_at(10);
    pll_lock = 1'b1;
    wait_at(25);

    done = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event cycle=%0d actual=none required=0x%h", e.cyc, e.val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
